// File: rtl/oq_pkg.sv
// Shared definitions for the output-queue ingress/egress path: write-word
// field layout and the packer FSM encoding.
package oq_pkg;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int BCNT_WIDTH      = 6;
  localparam int DATA_LSB        = 0;

  // Field positions depend on the data width, so they are offered as functions
  // for parameterised users and as constants for the default width.
  function automatic int word_width(input int tdata_bytes);
    return 8 * tdata_bytes + 10;
  endfunction

  function automatic int bcnt_lsb(input int tdata_bytes);
    return 8 * tdata_bytes;
  endfunction

  function automatic int sop_bit(input int tdata_bytes);
    return 8 * tdata_bytes + BCNT_WIDTH;
  endfunction

  function automatic int eop_bit(input int tdata_bytes);
    return 8 * tdata_bytes + BCNT_WIDTH + 1;
  endfunction

  localparam int WORD_WIDTH = word_width(DEF_TDATA_WIDTH);
  localparam int BCNT_LSB   = bcnt_lsb(DEF_TDATA_WIDTH);
  localparam int SOP_BIT    = sop_bit(DEF_TDATA_WIDTH);
  localparam int EOP_BIT    = eop_bit(DEF_TDATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } oq_state_e;

endpackage

// File: rtl/oq_dst_decode.sv
// Priority encoder from a destination one-hot to a queue id; the lowest set
// bit wins so multicast requests collapse onto a single queue.
module oq_dst_decode #(
  parameter int NUM_QUEUES     = 5,
  parameter int QUEUE_ID_WIDTH = 3
) (
  input  logic [NUM_QUEUES-1:0]     i_onehot,
  output logic [QUEUE_ID_WIDTH-1:0] o_qid,
  output logic                      o_valid
);

  always_comb begin
    o_qid   = '0;
    o_valid = 1'b0;
    // Scan downwards so the last hit, i.e. the lowest index, is kept.
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (i_onehot[i]) begin
        o_qid   = QUEUE_ID_WIDTH'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oq_ingress_packer.sv
// AXI4-Stream ingress packer: selects a queue per packet, drops packets for
// disabled/absent queues, and packs beats into controller write words.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a packet (SOP decision)
//   FWD   | forwarding remaining beats to the latched queue
//   DROP  | consuming and discarding remaining beats
module oq_ingress_packer
  import oq_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int TUSER_WIDTH    = 128,
  parameter int NUM_QUEUES     = 5,
  parameter int QUEUE_ID_WIDTH = 3,
  parameter int DST_PORT_POS   = 24,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8*TDATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [TDATA_WIDTH-1:0]      s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  input  logic [NUM_QUEUES-1:0]       queue_enable,
  output logic [QUEUE_ID_WIDTH-1:0]   write_queue_id,
  output logic [8*TDATA_WIDTH+9:0]    write_data,
  output logic                        write_data_valid,
  input  logic [NUM_QUEUES-1:0]       write_full,
  output logic [CNT_WIDTH-1:0]        pkt_fwd_count,
  output logic [CNT_WIDTH-1:0]        pkt_drop_count
);

  localparam int L_WORD_WIDTH = word_width(TDATA_WIDTH);
  localparam int L_BCNT_LSB   = bcnt_lsb(TDATA_WIDTH);
  localparam int L_SOP_BIT    = sop_bit(TDATA_WIDTH);
  localparam int L_EOP_BIT    = eop_bit(TDATA_WIDTH);

  oq_state_e                 r_state;
  oq_state_e                 w_state_next;
  logic [QUEUE_ID_WIDTH-1:0] r_pkt_qid;
  logic                      r_valid;
  logic [L_WORD_WIDTH-1:0]   r_word;
  logic [QUEUE_ID_WIDTH-1:0] r_qid;
  logic [CNT_WIDTH-1:0]      r_fwd_cnt;
  logic [CNT_WIDTH-1:0]      r_drop_cnt;

  logic [QUEUE_ID_WIDTH-1:0] w_dst_qid;
  logic                      w_dst_valid;
  logic                      w_dst_enabled;
  logic                      w_full_cur;
  logic                      w_drain;
  logic                      w_accept;
  logic                      w_tready;
  logic                      w_load;
  logic                      w_sop;
  logic                      w_drop_inc;
  logic                      w_latch_qid;
  logic [QUEUE_ID_WIDTH-1:0] w_load_qid;
  logic [BCNT_WIDTH-1:0]     w_bcnt;
  logic [L_WORD_WIDTH-1:0]   w_word;

  oq_dst_decode #(
    .NUM_QUEUES     (NUM_QUEUES),
    .QUEUE_ID_WIDTH (QUEUE_ID_WIDTH)
  ) u_dst_decode (
    .i_onehot (s_axis_tuser[DST_PORT_POS +: NUM_QUEUES]),
    .o_qid    (w_dst_qid),
    .o_valid  (w_dst_valid)
  );

  // Explicit compares keep out-of-range ids from selecting a nonexistent bit.
  always_comb begin
    w_dst_enabled = 1'b0;
    w_full_cur    = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (w_dst_qid == QUEUE_ID_WIDTH'(q)) w_dst_enabled = queue_enable[q];
      if (r_qid == QUEUE_ID_WIDTH'(q))     w_full_cur    = write_full[q];
    end
  end

  always_comb begin
    w_bcnt = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) begin
      w_bcnt = w_bcnt + BCNT_WIDTH'(s_axis_tkeep[i]);
    end
  end

  assign w_drain  = r_valid && !w_full_cur;
  assign w_tready = (r_state == ST_DROP) ? 1'b1 : (!r_valid || !w_full_cur);
  assign w_accept = s_axis_tvalid && w_tready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_sop        = 1'b0;
    w_drop_inc   = 1'b0;
    w_latch_qid  = 1'b0;
    w_load_qid   = r_pkt_qid;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_dst_valid || !w_dst_enabled) begin
            w_drop_inc   = 1'b1;
            w_state_next = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            w_load       = 1'b1;
            w_sop        = 1'b1;
            w_latch_qid  = 1'b1;
            w_load_qid   = w_dst_qid;
            w_state_next = s_axis_tlast ? ST_IDLE : ST_FWD;
          end
        end
      end
      ST_FWD: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_axis_tlast) w_state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_accept && s_axis_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_word                              = '0;
    w_word[DATA_LSB +: 8*TDATA_WIDTH]   = s_axis_tdata;
    w_word[L_BCNT_LSB +: BCNT_WIDTH]    = w_bcnt;
    w_word[L_SOP_BIT]                   = w_sop;
    w_word[L_EOP_BIT]                   = s_axis_tlast;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_qid <= '0;
    end else if (w_latch_qid) begin
      r_pkt_qid <= w_dst_qid;
    end
  end

  // Word register only reloads on a new beat, so a stalled word stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_qid   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_word  <= w_word;
      r_qid   <= w_load_qid;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drain && r_word[L_EOP_BIT]) r_fwd_cnt  <= r_fwd_cnt + CNT_WIDTH'(1);
      if (w_drop_inc)                   r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign s_axis_tready    = w_tready;
  assign write_queue_id   = r_qid;
  assign write_data       = r_word;
  assign write_data_valid = r_valid;
  assign pkt_fwd_count    = r_fwd_cnt;
  assign pkt_drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_oq_ingress_packer.sv
// Scoreboard bench for oq_ingress_packer: expected words are queued on beat
// acceptance and compared as the controller-side transfers occur.
module tb_oq_ingress_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [4:0]   queue_enable;
  logic [2:0]   write_queue_id;
  logic [265:0] write_data;
  logic         write_data_valid;
  logic [4:0]   write_full;
  logic [31:0]  pkt_fwd_count;
  logic [31:0]  pkt_drop_count;

  int errors = 0;
  int checks = 0;
  int m_fwd  = 0;
  int m_drop = 0;

  logic [268:0] sb_q[$];

  always #5 clk = ~clk;

  oq_ingress_packer dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .queue_enable     (queue_enable),
    .write_queue_id   (write_queue_id),
    .write_data       (write_data),
    .write_data_valid (write_data_valid),
    .write_full       (write_full),
    .pkt_fwd_count    (pkt_fwd_count),
    .pkt_drop_count   (pkt_drop_count)
  );

  // Transfer monitor: a word moves at the next posedge when valid and not full.
  always @(negedge clk) begin
    logic [268:0] exp_e;
    if (!reset && write_data_valid && !write_full[write_queue_id]) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got q=%0d word=%h, none expected", write_queue_id, write_data);
      end else begin
        exp_e = sb_q.pop_front();
        if ({write_queue_id, write_data} !== exp_e) begin
          errors++;
          $display("FAIL word: got q=%0d word=%h, expected q=%0d word=%h",
                   write_queue_id, write_data, exp_e[268:266], exp_e[265:0]);
        end
      end
    end
  end

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                           input logic last, input logic fwd, input logic [2:0] q, input logic sop);
    logic ok;
    logic [5:0] bc;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    bc = 6'($countones(k));
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        if (fwd) sb_q.push_back({q, 2'b00, last, sop, bc, d});
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL beat_timeout: tready=%b, expected 1 within 60 cycles", s_axis_tready);
    end
  endtask

  task automatic send_packet(input logic [4:0] dst, input int nbeats, input logic [31:0] lastkeep);
    logic [2:0]   q;
    logic         fwd;
    logic [127:0] u;
    q = 3'd0;
    for (int i = 4; i >= 0; i--) if (dst[i]) q = 3'(i);
    fwd = (dst != 5'd0) && queue_enable[q];
    if (fwd) m_fwd++;
    else     m_drop++;
    for (int b = 0; b < nbeats; b++) begin
      u = {$urandom, $urandom, $urandom, $urandom};
      if (b == 0) u[24 +: 5] = dst;
      send_beat(rand_data(), (b == nbeats - 1) ? lastkeep : 32'hFFFF_FFFF, u,
                b == nbeats - 1, fwd, q, b == 0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (pkt_fwd_count !== 32'(m_fwd)) begin
      errors++;
      $display("FAIL %s_fwd_count: got %0d, expected %0d", tag, pkt_fwd_count, m_fwd);
    end
    checks++;
    if (pkt_drop_count !== 32'(m_drop)) begin
      errors++;
      $display("FAIL %s_drop_count: got %0d, expected %0d", tag, pkt_drop_count, m_drop);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({write_data_valid, s_axis_tready, write_queue_id} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b tready=%b q=%0d, expected 0 1 0",
               write_data_valid, s_axis_tready, write_queue_id);
    end
    checks++;
    if (write_data !== 266'd0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", write_data);
    end
    check_counters("reset");
  endtask

  task automatic test_basic();
    send_packet(5'b00100, 3, 32'h0000_0FFF);
    // Last beat was accepted one edge ago; it must already be in the register.
    checks++;
    if ({write_data_valid, write_queue_id, write_data[263], write_data[261:256]} !== {1'b1, 3'd2, 1'b1, 6'd12}) begin
      errors++;
      $display("FAIL basic_latency: got valid=%b q=%0d eop=%b bcnt=%0d, expected 1 2 1 12",
               write_data_valid, write_queue_id, write_data[263], write_data[261:256]);
    end
    wait_drain();
    check_counters("basic");
  endtask

  task automatic test_stall();
    logic [265:0] held;
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0400_0000,
              1'b0, 1'b1, 3'd2, 1'b1);
    m_fwd++;
    write_full = 5'b00100;
    held = write_data;
    s_axis_tdata  = rand_data();
    s_axis_tkeep  = 32'hFFFF_FFFF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({s_axis_tready, write_data_valid} !== 2'b01 || write_data !== held) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d tready=%b valid=%b data_stable=%b, expected 0 1 1",
                 c, s_axis_tready, write_data_valid, write_data === held);
      end
      @(posedge clk);
      #1;
    end
    write_full = 5'b00000;
    send_beat(s_axis_tdata, 32'hFFFF_FFFF, 128'd0, 1'b0, 1'b1, 3'd2, 1'b0);
    send_beat(rand_data(), 32'h0000_0001, 128'd0, 1'b1, 1'b1, 3'd2, 1'b0);
    wait_drain();
    check_counters("stall");
  endtask

  task automatic test_drop();
    queue_enable = 5'b10111;
    send_packet(5'b00000, 2, 32'h0000_FFFF);
    send_packet(5'b01000, 3, 32'hFFFF_FFFF);
    wait_drain();
    check_counters("drop");
    queue_enable = 5'b11111;
  endtask

  task automatic test_multicast();
    send_packet(5'b10010, 1, 32'h0000_00FF);
    checks++;
    if ({write_queue_id, write_data[263:256]} !== {3'd1, 1'b1, 1'b1, 6'd8}) begin
      errors++;
      $display("FAIL multicast: got q=%0d eop=%b sop=%b bcnt=%0d, expected 1 1 1 8",
               write_queue_id, write_data[263], write_data[262], write_data[261:256]);
    end
    wait_drain();
  endtask

  task automatic test_other_full();
    write_full = 5'b00001;
    send_packet(5'b00010, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if ({write_data_valid, s_axis_tready} !== 2'b11) begin
      errors++;
      $display("FAIL other_full: got valid=%b tready=%b, expected 1 1", write_data_valid, s_axis_tready);
    end
    @(posedge clk);
    #1;
    wait_drain();
    write_full = 5'b00000;
    check_counters("other_full");
  endtask

  task automatic test_enable_midpkt();
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0800_0000,
              1'b0, 1'b1, 3'd3, 1'b1);
    m_fwd++;
    queue_enable = 5'b10111;
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'd0, 1'b0, 1'b1, 3'd3, 1'b0);
    send_beat(rand_data(), 32'h0000_0007, 128'd0, 1'b1, 1'b1, 3'd3, 1'b0);
    queue_enable = 5'b11111;
    wait_drain();
    check_counters("enable_mid");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_packet(5'b00001, 2, 32'h0000_0003);
        send_packet(5'b10000, 3, 32'h7FFF_FFFF);
        send_packet(5'b00000, 2, 32'hFFFF_FFFF);
        send_packet(5'b00100, 1, 32'h0000_0001);
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #2;
          write_full = 5'($urandom);
        end
        write_full = 5'b00000;
      end
    join
    wait_drain();
    check_counters("b2b");
  endtask

  task automatic test_reset_midpkt();
    write_full = 5'b00100;
    send_beat(rand_data(), 32'hFFFF_FFFF, 128'h0000_0000_0000_0000_0000_0000_0400_0000,
              1'b0, 1'b1, 3'd2, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    write_full = 5'b00000;
    m_fwd  = 0;
    m_drop = 0;
    checks++;
    if ({write_data_valid, s_axis_tready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_valid: got valid=%b tready=%b, expected 0 1", write_data_valid, s_axis_tready);
    end
    check_counters("reset_mid");
    send_packet(5'b00001, 2, 32'h00FF_FFFF);
    wait_drain();
    check_counters("after_reset");
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    queue_enable  = 5'b11111;
    write_full    = 5'b00000;
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_multicast();
    test_other_full();
    test_enable_midpkt();
    test_back_to_back();
    test_reset_midpkt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
